fetch_pc_ctrl: RTL
==================

# fetch_pc_ctrl

Fetch-stage program-counter controller for the five-stage MIPS pipeline. Holds the architectural F_PC register and picks each cycle's next fetch address from four sources: exception entry, eret return, hazard stall hold, and the combinational next-PC from the branch/jump logic. Drives the pipeline-register flush lines on a redirect. Tracks handler occupancy with a small FSM and flags fetch address errors (AdEL) for the CP0 path.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, F_PC value after reset
- HANDLER_PC, 32'h0000_4180, exception entry address
- IM_BASE, 32'h0000_3000, lowest legal fetch address
- IM_LIMIT, 32'h0000_6FFC, highest legal fetch address (inclusive)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; all state returns to reset values immediately
- stall  in  1  hazard unit: hold F_PC and F/D register
- npc  in  32  next-PC from the branch/jump/jr selector
- M_exc_req  in  1  CP0: exception/interrupt taken this cycle
- M_eret_req  in  1  eret in M stage
- EPC  in  32  CP0 return address
- F_PC  out  32  current fetch address (registered)
- flush_FD, flush_DE, flush_EM  out  1 each  clear the named pipeline register at the next edge
- F_exc_adel  out  1  fetch address error on current F_PC
- F_exccode  out  5  5'd4 when F_exc_adel, else 5'd0
- in_handler  out  1  FSM is in HANDLER
- eret_err  out  1  sticky: eret seen while in RUN
- exc_cnt  out  16  saturating count of accepted exceptions

## Operation
- Next-PC priority, evaluated every cycle: M_exc_req → HANDLER_PC; else M_eret_req → EPC; else stall → hold F_PC; else npc.
- Exception and eret override stall. When both are asserted in the same cycle, the exception wins and the eret is dropped.
- Flushes (combinational, same cycle as the request):
  - exception: flush_FD = flush_DE = flush_EM = 1
  - eret: flush_FD = flush_DE = 1, flush_EM = 0
  - otherwise all 0
- FSM states: RUN (encoding 0) and HANDLER (encoding 1).
  - RUN → HANDLER on M_exc_req.
  - HANDLER → RUN on M_eret_req without M_exc_req.
  - HANDLER + M_exc_req: nested exception; stay in HANDLER, redirect anyway, count it.
  - RUN + M_eret_req: still redirects to EPC; sets eret_err (cleared only by reset); state stays RUN.
- exc_cnt increments by 1 on every accepted exception and saturates at 16'hFFFF.
- AdEL is combinational on F_PC. It is 1 when F_PC[1:0] != 0, or when F_PC < IM_BASE or F_PC > IM_LIMIT (unsigned 32-bit compares). F_PC still advances normally; CP0 is responsible for raising M_exc_req later.
- The EPC and npc values are loaded unmodified; no alignment correction is applied.

## Timing
- Reset values: F_PC = RESET_PC, state = RUN, in_handler = 0, eret_err = 0, exc_cnt = 0. The flush outputs are 0 whenever the request inputs are 0.
- Latency: a request or npc sampled at edge N appears on F_PC after edge N, so the effect is visible in the next cycle. Flushes are asserted in the request cycle itself.
- Stall held for k cycles: F_PC is constant for k cycles, then takes npc.
- Reset asserted mid-redirect: the redirect is lost and F_PC = RESET_PC immediately. After deassertion the first edge loads npc, or a request target if one is present.
- exc_cnt wrap: once at FFFF it stays at FFFF; it never returns to 0.

## Structure
- Shared package pipeline_defs holds:
  - RESET_PC and HANDLER_PC constants
  - EXCCODE_ADEL = 5'd4 and EXCCODE_NONE = 5'd0
  - FSM state encoding
- One natural sub-module: pc_target_mux. It is combinational: it takes the priority select and the flush decode and returns next_pc plus the three flush bits.
- The top level keeps the F_PC register, the FSM, eret_err, exc_cnt and the AdEL compare.

## Test plan
- Reset release, stall = 0, npc = F_PC + 4 for 3 cycles → F_PC goes 3000, 3004, 3008, 300C; all flushes 0.
- stall = 1 for 2 cycles while npc = 3010 → F_PC holds 300C for 2 cycles, then becomes 3010.
- M_exc_req with stall = 1 → all three flushes are 1 that cycle; next cycle F_PC = 4180, in_handler = 1, exc_cnt = 1.
- In HANDLER, M_eret_req with EPC = 3020 → flush_FD and flush_DE are 1, flush_EM is 0; next cycle F_PC = 3020, in_handler = 0. A further eret in RUN sets eret_err = 1.
- M_exc_req and M_eret_req in the same cycle → F_PC = 4180, state = HANDLER. Then npc = 3002 → F_exc_adel = 1, F_exccode = 4. Then npc = 7000 → AdEL = 1.
- Force 65536 exceptions → exc_cnt = FFFF and stays there. Assert reset mid-stream → F_PC = 3000 and exc_cnt = 0 immediately.

Source files
------------

// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared pipeline definitions for the fetch stage: reset/handler vectors,
// exception codes and the handler-occupancy FSM encoding.
package pipeline_defs;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

    localparam logic [4:0] EXCCODE_ADEL = 5'd4;
    localparam logic [4:0] EXCCODE_NONE = 5'd0;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_HANDLER = 1'b1
    } pc_state_e;

endpackage

// File: rtl/fetch_pc_ctrl_pc_target_mux.sv
// Next fetch address select and redirect flush decode.
// Priority: exception > eret > stall hold > npc.
module pc_target_mux #(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic        stall,
    input  logic [31:0] cur_pc,
    input  logic [31:0] npc,
    input  logic [31:0] epc,
    output logic [31:0] next_pc,
    output logic        flush_fd,
    output logic        flush_de,
    output logic        flush_em
);

    always_comb begin
        next_pc  = npc;
        flush_fd = 1'b0;
        flush_de = 1'b0;
        flush_em = 1'b0;
        if (exc_req) begin
            next_pc  = HANDLER_PC;
            flush_fd = 1'b1;
            flush_de = 1'b1;
            flush_em = 1'b1;
        end else if (eret_req) begin
            // eret itself sits in M and must retire, so E/M is kept
            next_pc  = epc;
            flush_fd = 1'b1;
            flush_de = 1'b1;
        end else if (stall) begin
            next_pc = cur_pc;
        end
    end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC controller: F_PC register, handler-occupancy FSM,
// exception counter and fetch address-error detection.
module fetch_pc_ctrl
    import pipeline_defs::*;
#(
    parameter logic [31:0] RESET_PC   = pipeline_defs::RESET_PC,
    parameter logic [31:0] HANDLER_PC = pipeline_defs::HANDLER_PC,
    parameter logic [31:0] IM_BASE    = 32'h0000_3000,
    parameter logic [31:0] IM_LIMIT   = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] npc,
    input  logic        M_exc_req,
    input  logic        M_eret_req,
    input  logic [31:0] EPC,
    output logic [31:0] F_PC,
    output logic        flush_FD,
    output logic        flush_DE,
    output logic        flush_EM,
    output logic        F_exc_adel,
    output logic [4:0]  F_exccode,
    output logic        in_handler,
    output logic        eret_err,
    output logic [15:0] exc_cnt
);

    logic [31:0] next_pc;
    pc_state_e   state;

    pc_target_mux #(
        .HANDLER_PC (HANDLER_PC)
    ) u_mux (
        .exc_req  (M_exc_req),
        .eret_req (M_eret_req),
        .stall    (stall),
        .cur_pc   (F_PC),
        .npc      (npc),
        .epc      (EPC),
        .next_pc  (next_pc),
        .flush_fd (flush_FD),
        .flush_de (flush_DE),
        .flush_em (flush_EM)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) F_PC <= RESET_PC;
        else        F_PC <= next_pc;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_RUN;
            in_handler <= 1'b0;
            eret_err   <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (M_exc_req) begin
                        state      <= ST_HANDLER;
                        in_handler <= 1'b1;
                    end else if (M_eret_req) begin
                        eret_err <= 1'b1;
                    end
                end
                ST_HANDLER: begin
                    // a nested exception keeps us in the handler
                    if (!M_exc_req && M_eret_req) begin
                        state      <= ST_RUN;
                        in_handler <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_RUN;
                    in_handler <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                              exc_cnt <= 16'd0;
        else if (M_exc_req && exc_cnt != 16'hFFFF) exc_cnt <= exc_cnt + 16'd1;
    end

    always_comb begin
        F_exc_adel = (F_PC[1:0] != 2'b00) || (F_PC < IM_BASE) || (F_PC > IM_LIMIT);
        F_exccode  = F_exc_adel ? EXCCODE_ADEL : EXCCODE_NONE;
    end

endmodule
